// File: rtl/lsb_serial_comparator.sv
// Bit-serial unsigned magnitude comparator, operands arrive LSB first.
// A more significant unequal bit pair always overrides the running verdict.
module lsb_serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_bit_valid,
  input  logic i_a_bit,
  input  logic i_b_bit,
  output logic o_busy,
  output logic o_done,
  output logic o_gt,
  output logic o_eq,
  output logic o_lt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ,
    REL_GT,
    REL_LT
  } rel_t;

  state_t         r_state;
  state_t         w_state_next;
  rel_t           r_rel;
  rel_t           w_rel_next;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_next;
  logic           w_finish;
  logic           r_gt;
  logic           r_eq;
  logic           r_lt;

  always_comb begin
    w_state_next = r_state;
    w_rel_next   = r_rel;
    w_count_next = r_count;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = SHIFT;
          w_rel_next   = REL_EQ;
          w_count_next = '0;
        end
      end
      SHIFT: begin
        if (i_bit_valid) begin
          if (i_a_bit && !i_b_bit) begin
            w_rel_next = REL_GT;
          end else if (!i_a_bit && i_b_bit) begin
            w_rel_next = REL_LT;
          end
          w_count_next = r_count + CW'(1);
          if (r_count == LAST) begin
            w_state_next = DONE;
            w_finish     = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_rel   <= REL_EQ;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_rel   <= w_rel_next;
      r_count <= w_count_next;
    end
  end

  // Result is loaded on the final accepted pair so it is valid while DONE is shown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gt <= 1'b0;
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else if (w_finish) begin
      r_gt <= (w_rel_next == REL_GT);
      r_eq <= (w_rel_next == REL_EQ);
      r_lt <= (w_rel_next == REL_LT);
    end
  end

  assign o_busy = (r_state == SHIFT);
  assign o_done = (r_state == DONE);
  assign o_gt   = r_gt;
  assign o_eq   = r_eq;
  assign o_lt   = r_lt;

endmodule
